// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: turns each one-hot tour move into a vertical
// then a horizontal command, otherwise passes UART commands through. Optional: TOUR_CMD_FANFARE_EN.
module tour_cmd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tour_go,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

`ifdef TOUR_CMD_FANFARE_EN
    localparam logic [3:0] HORZ_OP = 4'h3;
`else
    localparam logic [3:0] HORZ_OP = 4'h2;
`endif
    localparam logic [3:0] VERT_OP   = 4'h2;
    localparam logic [4:0] LAST_MOVE = 5'd23;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    typedef enum logic [2:0] {IDLE, VERT, V_ACK, HORZ, H_ACK} state_t;

    state_t     state;
    logic [7:0] x_hdg, y_hdg;
    logic [3:0] x_sq,  y_sq;

    // Anything other than exactly one set bit decodes as a null move.
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        x_hdg = NORTH;
        x_sq  = 4'd0;
        y_hdg = NORTH;
        y_sq  = 4'd0;
        case (move)
            8'h01: begin x_hdg = WEST; x_sq = 4'd1; y_hdg = NORTH; y_sq = 4'd2; end
            8'h02: begin x_hdg = EAST; x_sq = 4'd1; y_hdg = NORTH; y_sq = 4'd2; end
            8'h04: begin x_hdg = WEST; x_sq = 4'd2; y_hdg = NORTH; y_sq = 4'd1; end
            8'h08: begin x_hdg = WEST; x_sq = 4'd2; y_hdg = SOUTH; y_sq = 4'd1; end
            8'h10: begin x_hdg = WEST; x_sq = 4'd1; y_hdg = SOUTH; y_sq = 4'd2; end
            8'h20: begin x_hdg = EAST; x_sq = 4'd1; y_hdg = SOUTH; y_sq = 4'd2; end
            8'h40: begin x_hdg = EAST; x_sq = 4'd2; y_hdg = SOUTH; y_sq = 4'd1; end
            8'h80: begin x_hdg = EAST; x_sq = 4'd2; y_hdg = NORTH; y_sq = 4'd1; end
            default: ;
        endcase
    end

    // NOTE: asynchronous active-low reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            case (state)
                IDLE: if (tour_go) begin
                    mv_indx <= 5'd0;
                    state   <= VERT;
                end
                VERT:  if (clr_cmd_rdy) state <= V_ACK;
                V_ACK: if (send_resp)   state <= HORZ;
                HORZ:  if (clr_cmd_rdy) state <= H_ACK;
                H_ACK: if (send_resp) begin
                    if (mv_indx == LAST_MOVE) begin
                        state <= IDLE;
                    end else begin
                        mv_indx <= mv_indx + 5'd1;
                        state   <= VERT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The command payload tracks move, which the tour store reads back for mv_indx.
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        case (state)
            VERT:  begin cmd = {VERT_OP, y_hdg, y_sq}; cmd_rdy = 1'b1; end
            V_ACK: begin cmd = {VERT_OP, y_hdg, y_sq}; cmd_rdy = 1'b0; end
            HORZ:  begin cmd = {HORZ_OP, x_hdg, x_sq}; cmd_rdy = 1'b1; end
            H_ACK: begin cmd = {HORZ_OP, x_hdg, x_sq}; cmd_rdy = 1'b0; end
            default: ;
        endcase
    end

    assign resp = (state != IDLE && mv_indx != LAST_MOVE) ? 8'h5A : 8'hA5;

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized directed bench for tour_cmd against a move-geometry reference model.
module tb_tour_cmd;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tour_go;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    int n_cmp = 0;
    int n_err = 0;

`ifdef TOUR_CMD_FANFARE_EN
    localparam logic [3:0] HOP = 4'h3;
`else
    localparam logic [3:0] HOP = 4'h2;
`endif

    // Knight displacement per one-hot bit.
    int DX [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
    int DY [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

    logic [7:0] tour [24];
    assign move = (mv_indx < 5'd24) ? tour[mv_indx] : 8'h00;

    tour_cmd dut (
        .clk(clk), .rst_n(rst_n), .tour_go(tour_go), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_cmd(input logic [7:0] mv, input bit vert);
        int dx = 0, dy = 0, d;
        logic [7:0] h;
        if ($countones(mv) == 1)
            for (int i = 0; i < 8; i++) if (mv[i]) begin dx = DX[i]; dy = DY[i]; end
        d = vert ? dy : dx;
        if (d == 0)      h = 8'h00;
        else if (vert)   h = (d < 0) ? 8'h7F : 8'h00;
        else             h = (d < 0) ? 8'h3F : 8'hBF;
        if (d < 0) d = -d;
        return {(vert ? 4'h2 : HOP), h, 4'(d)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_phase(input string tag, input int k, input bit vert, input bit rdy);
        check({tag, "_cmd"}, cmd, model_cmd(tour[k], vert));
        check({tag, "_rdy"}, {15'd0, cmd_rdy}, {15'd0, rdy});
        check({tag, "_idx"}, {11'd0, mv_indx}, 16'(k));
        check({tag, "_resp"}, {8'd0, resp}, (k == 23) ? 16'h00A5 : 16'h005A);
    endtask

    task automatic check_idle(input string tag, input int idx);
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'($urandom);
        settle();
        check({tag, "_cmd"}, cmd, cmd_UART);
        check({tag, "_rdy"}, {15'd0, cmd_rdy}, {15'd0, cmd_rdy_UART});
        check({tag, "_resp"}, {8'd0, resp}, 16'h00A5);
        check({tag, "_idx"}, {11'd0, mv_indx}, 16'(idx));
    endtask

    task automatic run_tour(input int reset_at);
        cmd_UART = 16'($urandom);
        tour_go = 1'b1;
        tick();
        tour_go = 1'b0;
        settle();
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 2)) begin
                check_phase("vert_wait", k, 1'b1, 1'b1);
                tick();
                settle();
            end
            if (k == 1) begin
                // Stray send_resp, tour_go and UART strobe while busy must do nothing.
                send_resp = 1'b1; tour_go = 1'b1; cmd_rdy_UART = 1'b1; cmd_UART = 16'($urandom);
                tick();
                send_resp = 1'b0; tour_go = 1'b0; cmd_rdy_UART = 1'b0;
                settle();
                check_phase("vert_ignore", k, 1'b1, 1'b1);
            end
            check_phase("vert", k, 1'b1, 1'b1);
            clr_cmd_rdy = 1'b1;
            send_resp   = 1'($urandom);
            tick();
            clr_cmd_rdy = 1'b0; send_resp = 1'b0;
            settle();
            check_phase("v_ack", k, 1'b1, 1'b0);
            tick();
            settle();
            check_phase("v_ack_hold", k, 1'b1, 1'b0);
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            settle();
            check_phase("horz", k, 1'b0, 1'b1);
            clr_cmd_rdy = 1'b1;
            send_resp   = 1'($urandom);
            tick();
            clr_cmd_rdy = 1'b0; send_resp = 1'b0;
            settle();
            check_phase("h_ack", k, 1'b0, 1'b0);
            if (k == reset_at) begin
                rst_n = 1'b0;
                check_idle("mid_reset", 0);
                tick();
                rst_n = 1'b1;
                tick();
                check_idle("post_reset", 0);
                return;
            end
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            settle();
        end
        check_idle("tour_end", 23);
        tick();
        check_idle("tour_end_hold", 23);
    endtask

    initial begin
        rst_n = 1'b0; tour_go = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        for (int i = 0; i < 24; i++) tour[i] = 8'h01 << $urandom_range(0, 7);
        #2;
        check_idle("reset", 0);
        tick();
        rst_n = 1'b1;
        tick();

        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        settle();
        check("pass_cmd", cmd, 16'h1234);
        check("pass_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("pass_resp", {8'd0, resp}, 16'h00A5);
        repeat (4) begin
            tick();
            check_idle("pass_rand", 0);
        end
        cmd_rdy_UART = 1'b0;

        // Fixed moves at the head, null moves in the middle.
        tour[0] = 8'h01; tour[1] = 8'h40; tour[5] = 8'h00; tour[6] = 8'h03; tour[7] = 8'hFF;
        run_tour(-1);
        tick();
        check_idle("between", 23);

        for (int i = 0; i < 24; i++) tour[i] = 8'h01 << $urandom_range(0, 7);
        tour[0] = 8'h01;
        tour_go = 1'b1;
        tick();
        tour_go = 1'b0;
        settle();
        check("req032_vert", cmd, 16'h2002);
        check("req032_idx", {11'd0, mv_indx}, 16'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        run_tour(10);
        for (int i = 0; i < 24; i++) tour[i] = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h01 << $urandom_range(0, 7);
        run_tour(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port tour_go, input, 1, one-cycle pulse when the solved 24-move tour is available.
REQ-004 SHALL have port move, input, 8, one-hot move read back combinationally for mv_indx.
REQ-005 SHALL have port mv_indx, output, 5, index of the tour move being executed.
REQ-006 SHALL have port cmd_UART, input, 16, command from the serial path.
REQ-007 SHALL have port cmd_rdy_UART, input, 1, cmd_UART valid.
REQ-008 SHALL have port cmd, output, 16, command to the command processor: [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-009 SHALL have port cmd_rdy, output, 1, cmd valid.
REQ-010 SHALL have port clr_cmd_rdy, input, 1, consumer accepted cmd.
REQ-011 SHALL have port send_resp, input, 1, consumer finished executing cmd.
REQ-012 SHALL have port resp, output, 8, response byte to the host.

Function
REQ-013 SHALL decode move (dx,dy): bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1).
REQ-014 SHALL use headings: north (+y) 8'h00, west (-x) 8'h3F, south (-y) 8'h7F, east (+x) 8'hBF; squares = |d|.
REQ-015 SHALL use states IDLE, VERT, V_ACK, HORZ, H_ACK.
REQ-016 SHALL in IDLE pass through: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART.
REQ-017 SHALL on tour_go in IDLE clear mv_indx to 0 and enter VERT next cycle.
REQ-018 SHALL in VERT drive cmd = {4'h2, y heading, |dy|}, cmd_rdy=1; on clr_cmd_rdy go to V_ACK.
REQ-019 SHALL in V_ACK drive cmd_rdy=0, hold cmd; on send_resp go to HORZ.
REQ-020 SHALL in HORZ drive cmd = {horizontal opcode, x heading, |dx|}, cmd_rdy=1; on clr_cmd_rdy go to H_ACK.
REQ-021 SHALL in H_ACK drive cmd_rdy=0; on send_resp: mv_indx==23 -> IDLE, else mv_indx+1 and VERT.
REQ-022 SHALL drive resp = 8'h5A while not IDLE and mv_indx != 23, else 8'hA5.
REQ-023 SHALL ignore tour_go and cmd_rdy_UART outside IDLE.
REQ-024 SHALL ignore send_resp in VERT/HORZ; clr_cmd_rdy with send_resp in VERT/HORZ advances only to the ACK state.
REQ-025 SHALL for non-one-hot move (incl. 8'h00) issue both commands with heading 8'h00, squares 0, handshake unchanged.
REQ-026 SHALL never modify mv_indx beyond 23 (no wrap).

Reset
REQ-027 SHALL on rst_n low enter IDLE, mv_indx=0, regardless of state, including mid-tour.
REQ-028 SHALL after reset output cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.

Configuration
REQ-029 SHALL, with TOUR_CMD_FANFARE_EN defined, use horizontal opcode 4'h3 (move with fanfare).
REQ-030 SHALL, without TOUR_CMD_FANFARE_EN, use horizontal opcode 4'h2; all else identical.

Verification
REQ-031 SHALL cover: IDLE, cmd_UART=16'h1234, cmd_rdy_UART=1 -> cmd=16'h1234, cmd_rdy=1, resp=8'hA5.
REQ-032 SHALL cover: tour_go, move=8'h01, FANFARE_EN -> cmd 16'h2002, ack/resp, then 16'h33F1, mv_indx->1.
REQ-033 SHALL cover: move=8'h40, FANFARE_EN off -> cmd 16'h27F1 then 16'h2BF2.
REQ-034 SHALL cover: full 24-move tour -> 48 commands, resp 8'h5A until mv_indx 23, then 8'hA5, IDLE.
REQ-035 SHALL cover: send_resp in VERT before clr_cmd_rdy -> no state change; tour_go mid-tour ignored.
REQ-036 SHALL cover: rst_n low in H_ACK at mv_indx 10 -> IDLE, mv_indx=0, UART passthrough.
